ccff_chain_loader: RTL
======================

# ccff_chain_loader

Bitstream loader that drives the head of an FPGA configuration-chain (ccff) segment. It accepts configuration words over a valid/ready stream and serialises them MSB-first onto `ccff_head`, one bit per enabled `prog_clk` cycle, until exactly `CHAIN_LEN` bits have been shifted. It sits directly upstream of the I/O and logic tiles' `ccff_head` inputs and observes the chain's final `ccff_tail` to produce a readback count of the previous configuration.

## Interface
- `CHAIN_LEN`, default 20, total configuration bits in the driven chain (≥1).
- `DATA_W`, default 8, configuration word width (≥2).
- `prog_clk` input 1: programming clock; all state changes on its rising edge.
- `prog_reset` input 1: reset, asynchronous and active-high.
- `start` input 1: one-cycle request to begin a load; honoured only in IDLE or DONE.
- `s_data` input DATA_W: configuration word; bit DATA_W-1 is shifted first.
- `s_valid` input 1: `s_data` valid.
- `s_ready` output 1: loader accepts `s_data` this cycle.
- `ccff_head` output 1: serial bit into the chain.
- `chain_en` output 1: chain shift enable (gates chain clocking); the chain advances only on cycles with `chain_en`=1.
- `ccff_tail` input 1: serial bit returning from the chain end.
- `busy` output 1: high in FETCH or SHIFT.
- `done` output 1: high in DONE, until the next `start` or reset.
- `tail_ones` output clog2(CHAIN_LEN+1): count of 1s sampled on `ccff_tail` during the load.

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE/DONE + `start` -> FETCH. This clears `bit_total`, `tail_ones`, and `done`. `start` is ignored in FETCH and SHIFT.
- FETCH: `s_ready`=1 and `chain_en`=0. On `s_valid`&&`s_ready`, load the shifter with `s_data`, set `bit_idx`=0, and go to SHIFT.
- SHIFT: `chain_en`=1 and `ccff_head`=shifter[DATA_W-1]. Each cycle:
  - shift the shifter left by 1 and increment `bit_idx` and `bit_total`;
  - add `ccff_tail` into `tail_ones`.
- Word boundary (`bit_idx`=DATA_W-1 and `bit_total`+1<CHAIN_LEN):
  - `s_ready`=1 in the same cycle.
  - If `s_valid`, load the next word and stay in SHIFT, with no bubble.
  - Otherwise go to FETCH. The chain stalls (`chain_en`=0) until a word arrives.
- Final bit (`bit_total`+1=CHAIN_LEN): go to DONE. Unused low bits of the last word are discarded. `s_ready`=0.
- DONE: `chain_en`=0 and `s_ready`=0. `tail_ones` holds its value.
- `ccff_head` is 0 whenever `chain_en`=0.

## Timing
- Reset values: state IDLE; `s_ready`, `chain_en`, `ccff_head`, `busy`, `done` = 0; `tail_ones`=0; shifter and counters = 0.
- Reset asserted mid-load aborts immediately and asynchronously: `chain_en` drops the same instant. The chain contents are then undefined, and a full reload is required.
- `start` at edge N -> FETCH at N+1. First accepted word at edge M -> first `chain_en`=1 cycle is M+1.
- Unstalled load takes exactly CHAIN_LEN `chain_en` cycles over ceil(CHAIN_LEN/DATA_W) words. `done` rises on the edge after the last shift cycle.
- `tail_ones` samples `ccff_tail` only on `chain_en`=1 cycles.
- Counter widths: `bit_idx` is clog2(DATA_W); `bit_total` and `tail_ones` are clog2(CHAIN_LEN+1). No wrap is possible.

## Structure
- Shared package `ccff_loader_pkg`: state enum (IDLE, FETCH, SHIFT, DONE) and a `ccff_cnt_w(n)` width function.
- One sub-module, `ccff_word_shifter`: a DATA_W load/shift register with `bit_idx` and a `last_bit` flag. The FSM, `bit_total`, and `tail_ones` live in the top level.

## Test plan
- Reset/idle: hold `prog_reset` then release -> all outputs 0; `s_valid`=1 without `start` -> `s_ready` stays 0.
- Back-to-back load (CHAIN_LEN=20, DATA_W=8): words 0xA5, 0x3C, 0xF0 always valid.
  - `chain_en` is high for exactly 20 consecutive cycles.
  - `ccff_head` sequence is 10100101 00111100 1111; low nibble 0000 is discarded.
  - `done` rises the next cycle.
- Stall: drop `s_valid` for 3 cycles at the word boundary -> `chain_en`=0 for those cycles, no bits are lost, and the head sequence is unchanged.
- Readback: chain model preloaded with 0b1011 repeated to 20 bits -> `tail_ones`=15 at `done`; reloading the same content returns the same count.
- Reset mid-SHIFT after 9 bits -> IDLE immediately, `chain_en`=0, `tail_ones`=0. A new `start` performs a full 20-bit load.
- `start` pulsed during SHIFT -> ignored, with no counter change. `start` in DONE -> `done` clears and a new load begins.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared state encoding and counter width helper for the ccff loader
package ccff_loader_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  function automatic int ccff_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// rtl/ccff_word_shifter.sv - MSB-first word shift register with bit index and last-bit flag
module ccff_word_shifter
  import ccff_loader_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              msb,
  output logic              last_bit
);

  localparam int IW = ccff_cnt_w(DATA_W);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;

  // A load on the word boundary replaces the shift so the next word follows without a bubble.
  always_comb begin
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    if (load) begin
      shreg_d   = data;
      bit_idx_d = '0;
    end else if (shift) begin
      shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
      bit_idx_d = bit_idx_q + 1'b1;
    end
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      shreg_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign msb      = shreg_q[DATA_W-1];
  assign last_bit = (bit_idx_q == IW'(DATA_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - streams configuration words MSB-first into a ccff chain and counts tail ones
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int DATA_W    = 8
) (
  input  logic                                  prog_clk,
  input  logic                                  prog_reset,
  input  logic                                  start,
  input  logic [DATA_W-1:0]                     s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic                                  ccff_head,
  output logic                                  chain_en,
  input  logic                                  ccff_tail,
  output logic                                  busy,
  output logic                                  done,
  output logic [ccff_cnt_w(CHAIN_LEN+1)-1:0]    tail_ones
);

  localparam int             CW        = ccff_cnt_w(CHAIN_LEN + 1);
  localparam logic [CW-1:0]  FINAL_IDX = CW'(CHAIN_LEN - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] bit_total_q, bit_total_d;
  logic [CW-1:0] tail_ones_q, tail_ones_d;
  logic          chain_en_q, chain_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load, shift, msb, last_bit, final_bit;

  ccff_word_shifter #(.DATA_W(DATA_W)) u_shifter (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .load       (load),
    .shift      (shift),
    .data       (s_data),
    .msb        (msb),
    .last_bit   (last_bit)
  );

  assign final_bit = (bit_total_q == FINAL_IDX);

  always_comb begin
    state_d     = state_q;
    bit_total_d = bit_total_q;
    tail_ones_d = tail_ones_q;
    chain_en_d  = chain_en_q;
    busy_d      = busy_q;
    done_d      = done_q;
    load        = 1'b0;
    shift       = 1'b0;
    s_ready     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = FETCH;
          bit_total_d = '0;
          tail_ones_d = '0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end
      FETCH: begin
        s_ready = 1'b1;
        if (s_valid) begin
          load       = 1'b1;
          state_d    = SHIFT;
          chain_en_d = 1'b1;
        end
      end
      SHIFT: begin
        shift       = 1'b1;
        bit_total_d = bit_total_q + 1'b1;
        tail_ones_d = tail_ones_q + CW'(ccff_tail);
        // The final bit wins over a coincident word boundary: leftover word bits are dropped.
        if (final_bit) begin
          state_d    = DONE;
          chain_en_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (last_bit) begin
          s_ready = 1'b1;
          if (s_valid) begin
            load = 1'b1;
          end else begin
            state_d    = FETCH;
            chain_en_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      bit_total_q <= '0;
      tail_ones_q <= '0;
      chain_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_total_q <= bit_total_d;
      tail_ones_q <= tail_ones_d;
      chain_en_q  <= chain_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign chain_en  = chain_en_q;
  assign ccff_head = chain_en_q & msb;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tail_ones = tail_ones_q;

endmodule
